menu_navigator: RTL and testbench



---
 rtl/menu_navigator_pkg.sv | 28 ++
 rtl/menu_navigator_inactivity_timer.sv | 46 ++++
 rtl/menu_navigator.sv | 154 +++++++++++++++
 tb/tb_menu_navigator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/menu_navigator_pkg.sv
// ============================================================================
//  Module   : menu_navigator_pkg
//  Purpose  : Shared definitions for the menu navigator and the game core:
//             navigator state encoding and the menu item codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package menu_navigator_pkg;

    // Navigator states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BROWSE = 2'd1,
        ST_ISSUE  = 2'd2
    } state_t;

    // Menu item codes, shared with the game core
    localparam logic [2:0] ITEM_FEED     = 3'd0;
    localparam logic [2:0] ITEM_PLAY     = 3'd1;
    localparam logic [2:0] ITEM_SLEEP    = 3'd2;
    localparam logic [2:0] ITEM_CLEAN    = 3'd3;
    localparam logic [2:0] ITEM_MEDICINE = 3'd4;
    localparam logic [2:0] ITEM_STATUS   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/menu_navigator_inactivity_timer.sv
// ============================================================================
//  Module   : inactivity_timer
//  Purpose  : Counts idle cycles while enabled; strobes 'expired' for one
//             cycle when the count reaches TIMEOUT-1.
//  Ports    : clk, rst_n (async, active-low), enable (count while high,
//             held at 0 while low), clear (restart from 0), expired (strobe).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inactivity_timer #(
    parameter int unsigned TIMEOUT = 10_000_000,
    parameter int unsigned TO_W    = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [TO_W-1:0] C_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        expired = enable && (count_q == C_LAST);
        count_d = count_q + TO_W'(1);
        // Disabled means frozen at 0, so every entry to counting starts fresh
        if (!enable || clear || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/menu_navigator.sv
// ============================================================================
//  Module   : menu_navigator
//  Purpose  : Turns debounced button pulses into a wrapping menu cursor and
//             a valid/ready action handshake; drops back to the home screen
//             after an inactivity timeout.
//  Ports    : clk, rst_n (async, active-low)
//             b_left/b_right/b_ok/b_back : one-cycle button pulses
//             act_ready   : game core accepts pending action
//             menu_active : high in BROWSE and ISSUE
//             cursor      : highlighted item
//             act_valid/act_code : pending action and its item index
//             beep        : one-cycle pulse per accepted press
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module menu_navigator
    import menu_navigator_pkg::*;
#(
    parameter int unsigned N_ITEMS = 6,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 10_000_000,
    parameter int unsigned TO_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             b_left,
    input  logic             b_right,
    input  logic             b_ok,
    input  logic             b_back,
    input  logic             act_ready,
    output logic             menu_active,
    output logic [IDX_W-1:0] cursor,
    output logic             act_valid,
    output logic [IDX_W-1:0] act_code,
    output logic             beep
);

    localparam logic [IDX_W-1:0] C_LAST_ITEM = IDX_W'(N_ITEMS - 1);

    state_t           state_q,       state_d;
    logic [IDX_W-1:0] cursor_q,      cursor_d;
    logic [IDX_W-1:0] act_code_q,    act_code_d;
    logic             act_valid_q,   act_valid_d;
    logic             beep_q,        beep_d;
    logic             menu_active_q, menu_active_d;

    logic             press;      // accepted press while browsing
    logic             timer_exp;
    logic             any_btn;

    assign any_btn = b_left | b_right | b_ok | b_back;

    inactivity_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state_q == ST_BROWSE),
        .clear   (press),
        .expired (timer_exp)
    );

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        act_code_d  = act_code_q;
        act_valid_d = act_valid_q;
        press       = 1'b0;
        beep_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Waking press only opens the menu; it does not navigate
                if (any_btn) begin
                    state_d  = ST_BROWSE;
                    cursor_d = '0;
                    beep_d   = 1'b1;
                end
            end

            ST_BROWSE: begin
                if (b_back) begin
                    press    = 1'b1;
                    state_d  = ST_IDLE;
                    cursor_d = '0;
                end else if (b_ok) begin
                    press       = 1'b1;
                    state_d     = ST_ISSUE;
                    act_code_d  = cursor_q;
                    act_valid_d = 1'b1;
                end else if (b_left ^ b_right) begin
                    press = 1'b1;
                    if (b_left) begin
                        cursor_d = (cursor_q == '0) ? C_LAST_ITEM
                                                    : cursor_q - IDX_W'(1);
                    end else begin
                        cursor_d = (cursor_q == C_LAST_ITEM) ? '0
                                                             : cursor_q + IDX_W'(1);
                    end
                end else if (timer_exp) begin
                    // Expiry only counts when no press was accepted this cycle
                    state_d  = ST_IDLE;
                    cursor_d = '0;
                end
                beep_d = press;
            end

            ST_ISSUE: begin
                // Buttons ignored; wait for the core to take the action
                if (act_valid_q && act_ready) begin
                    act_valid_d = 1'b0;
                    state_d     = ST_BROWSE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cursor_d    = '0;
                act_valid_d = 1'b0;
            end
        endcase

        menu_active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cursor_q      <= '0;
            act_code_q    <= '0;
            act_valid_q   <= 1'b0;
            beep_q        <= 1'b0;
            menu_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            act_code_q    <= act_code_d;
            act_valid_q   <= act_valid_d;
            beep_q        <= beep_d;
            menu_active_q <= menu_active_d;
        end
    end

    assign menu_active = menu_active_q;
    assign cursor      = cursor_q;
    assign act_valid   = act_valid_q;
    assign act_code    = act_code_q;
    assign beep        = beep_q;

endmodule

`default_nettype wire

// File: tb/tb_menu_navigator.sv
// ============================================================================
//  Module   : tb_menu_navigator
//  Purpose  : Self-checking bench for menu_navigator (TIMEOUT shortened to 8)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_menu_navigator;

    localparam int unsigned C_TIMEOUT = 8;

    logic       clk;
    logic       rst_n;
    logic       b_left, b_right, b_ok, b_back, act_ready;
    logic       menu_active;
    logic [2:0] cursor;
    logic       act_valid;
    logic [2:0] act_code;
    logic       beep;

    int         n_vec;
    int         n_bad;

    typedef struct {
        logic       l, r, o, b, rdy;
        logic       ma;
        logic [2:0] cur;
        logic       av;
        logic [2:0] ac;
        logic       bp;
    } vec_t;

    vec_t vecs[$];

    menu_navigator #(
        .N_ITEMS (6),
        .IDX_W   (3),
        .TIMEOUT (C_TIMEOUT),
        .TO_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .b_left      (b_left),
        .b_right     (b_right),
        .b_ok        (b_ok),
        .b_back      (b_back),
        .act_ready   (act_ready),
        .menu_active (menu_active),
        .cursor      (cursor),
        .act_valid   (act_valid),
        .act_code    (act_code),
        .beep        (beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic l, r, o, b, rdy,
                       input logic ma, input logic [2:0] cur,
                       input logic av, input logic [2:0] ac, input logic bp);
        vec_t v;
        v.l = l; v.r = r; v.o = o; v.b = b; v.rdy = rdy;
        v.ma = ma; v.cur = cur; v.av = av; v.ac = ac; v.bp = bp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic ma, input logic [2:0] cur,
                         input logic av, input logic [2:0] ac, input logic bp);
        n_vec++;
        if (menu_active !== ma || cursor !== cur || act_valid !== av ||
            act_code !== ac || beep !== bp) begin
            n_bad++;
            $display("FAIL %s: got ma=%b cur=%0d av=%b ac=%0d beep=%b, want ma=%b cur=%0d av=%b ac=%0d beep=%b",
                     name, menu_active, cursor, act_valid, act_code, beep,
                     ma, cur, av, ac, bp);
        end
    endtask

    // One clock: drive pulses, let the edge sample them, then clear
    task automatic step(input logic l, r, o, b, rdy);
        b_left = l; b_right = r; b_ok = o; b_back = b; act_ready = rdy;
        @(posedge clk);
        #1;
        b_left = 0; b_right = 0; b_ok = 0; b_back = 0; act_ready = 0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 0;
        b_left = 0; b_right = 0; b_ok = 0; b_back = 0; act_ready = 0;

        //   l r o b rdy | ma cur av ac bp
        add(0,1,0,0,0,  1,0,0,0,1);  // wake, cursor 0
        add(1,0,0,0,0,  1,5,0,0,1);  // left wraps 0 -> 5
        add(0,1,0,0,0,  1,0,0,0,1);  // right wraps 5 -> 0
        add(0,1,0,0,0,  1,1,0,0,1);
        add(0,1,0,0,0,  1,2,0,0,1);
        add(0,1,0,0,0,  1,3,0,0,1);
        add(0,1,0,0,0,  1,4,0,0,1);
        add(0,1,0,0,0,  1,5,0,0,1);
        add(0,1,0,0,0,  1,0,0,0,1);  // wrap again
        add(1,1,0,0,0,  1,0,0,0,0);  // left+right: no move, no beep
        add(0,1,0,0,0,  1,1,0,0,1);
        add(0,1,0,0,0,  1,2,0,0,1);
        add(0,0,1,0,0,  1,2,1,2,1);  // ok -> ISSUE code 2
        add(0,1,0,0,0,  1,2,1,2,0);  // ignored in ISSUE
        add(0,1,0,0,0,  1,2,1,2,0);
        add(0,1,0,0,0,  1,2,1,2,0);
        add(1,1,1,1,0,  1,2,1,2,0);
        add(0,0,0,0,1,  1,2,0,2,0);  // ack -> BROWSE, cursor kept
        add(0,0,0,0,1,  1,2,0,2,0);  // ready without valid ignored
        add(0,0,1,1,0,  0,0,0,2,1);  // back beats ok
        add(0,0,0,0,0,  0,0,0,2,0);
        add(0,0,0,1,0,  1,0,0,2,1);  // back also wakes

        #12;
        check("reset_state", 0, 0, 0, 0, 0);
        rst_n = 1;
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].l, vecs[i].r, vecs[i].o, vecs[i].b, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].ma, vecs[i].cur,
                  vecs[i].av, vecs[i].ac, vecs[i].bp);
        end

        // Timeout with no presses: IDLE exactly TIMEOUT cycles after entry
        for (int k = 1; k <= int'(C_TIMEOUT); k++) begin
            step(0,0,0,0,0);
            check($sformatf("to_idle_k%0d", k), (k < int'(C_TIMEOUT)), 0, 0, 2, 0);
        end

        // Press in the expiry cycle wins and restarts the timer
        step(0,1,0,0,0);
        check("to2_wake", 1, 0, 0, 2, 1);
        for (int k = 1; k < int'(C_TIMEOUT); k++) begin
            step(0,0,0,0,0);
            check($sformatf("to2_wait_k%0d", k), 1, 0, 0, 2, 0);
        end
        step(0,1,0,0,0);
        check("to2_press_at_expiry", 1, 1, 0, 2, 1);
        for (int k = 1; k <= int'(C_TIMEOUT); k++) begin
            step(0,0,0,0,0);
            check($sformatf("to2_after_k%0d", k), (k < int'(C_TIMEOUT)),
                  (k < int'(C_TIMEOUT)) ? 3'd1 : 3'd0, 0, 2, 0);
        end

        // ISSUE is immune to the timeout; full TIMEOUT counted from ack
        step(0,0,0,1,0);
        check("iss_wake", 1, 0, 0, 2, 1);
        step(0,0,1,0,0);
        check("iss_enter", 1, 0, 1, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            step(0,0,0,0,0);
            check($sformatf("iss_hold_k%0d", k), 1, 0, 1, 0, 0);
        end
        step(0,0,0,0,1);
        check("iss_ack", 1, 0, 0, 0, 0);
        for (int k = 1; k <= int'(C_TIMEOUT); k++) begin
            step(0,0,0,0,0);
            check($sformatf("iss_to_k%0d", k), (k < int'(C_TIMEOUT)), 0, 0, 0, 0);
        end

        // Asynchronous reset mid-ISSUE with cursor=3
        step(0,1,0,0,0);
        step(0,1,0,0,0);
        step(0,1,0,0,0);
        step(0,1,0,0,0);
        check("rst_pre_cursor", 1, 3, 0, 0, 1);
        step(0,0,1,0,0);
        check("rst_pre_issue", 1, 3, 1, 3, 1);
        #3;
        rst_n = 0;
        #1;
        check("rst_async_clear", 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        step(0,1,0,0,0);
        check("rst_wake", 1, 0, 0, 0, 1);
        step(0,0,0,0,0);
        check("rst_beep_one_cycle", 1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
